idli_shseq_m: RTL
=================

# idli_shseq_m

Sequencer for the single-position bit-serial shifter. It accepts a shift request carrying an op and an amount of 0–15. It then drives the shifter's slice counter and op across N back-to-back 4-cycle passes over the 16-bit operand, one position per pass. It sits between the EX issue logic and the shifter, and signals EX when the result and the final carry out are valid.

## Interface
Parameters:
- NO_PARAMS — none; word width is fixed at 16 bits (4 slices of 4 bits, `ctr_t` 2 bits) by `idli_pkg`.

Ports:
- `i_shseq_gck`  in  1  clock.
- `i_shseq_rst`  in  1  reset, synchronous, active-high.
- `i_shseq_req_vld`  in  1  shift request valid.
- `o_shseq_req_rdy`  out  1  sequencer can accept a request.
- `i_shseq_req_op`  in  `shift_op_t`  requested shift op.
- `i_shseq_req_amt`  in  4  shift amount (positions).
- `i_shseq_kill`  in  1  flush; abandon any sequence in progress.
- `o_shseq_run`  out  1  shifter slice active this cycle; the datapath writes the slice back.
- `o_shseq_ctr`  out  `ctr_t`  slice counter to the shifter.
- `o_shseq_op`  out  `shift_op_t`  op to the shifter.
- `o_shseq_last`  out  1  current pass is the final pass.
- `o_shseq_done`  out  1  one-cycle pulse: result complete; EX captures the shifter carry out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `o_shseq_req_rdy`=1.
  - On `vld & rdy`, latch op and amount.
  - Amount 0 → DONE. Otherwise → RUN with ctr=0 and passes remaining = amount.
- RUN:
  - `o_shseq_run`=1 and `o_shseq_op` = the latched op.
  - `o_shseq_ctr` increments 0,1,2,3 and wraps.
  - At ctr=3: decrement passes remaining. If it was 1 → DONE, otherwise continue with ctr=0.
  - `o_shseq_last`=1 whenever passes remaining = 1.
- DONE:
  - `o_shseq_done`=1 for exactly one cycle, with `run`=0 and `rdy`=0.
  - → IDLE.
- Kill:
  - In any state, `i_shseq_kill` forces the next state to IDLE and suppresses `done`.
  - Kill in the same cycle as a request handshake: kill wins and the request is dropped.
  - `rdy` stays high during kill in IDLE, but a request presented in that cycle is ignored.
- Request inputs are sampled only at the handshake. Changes while busy are ignored.
- Outside RUN: `o_shseq_ctr`=0 and `o_shseq_op` holds its last value. The shifter must see a stable op so its stash flop does not corrupt.
- Passes counter is 4 bits. Wrap-around cannot occur because the amount is at most 15.

## Timing
- Reset values: state IDLE, `o_shseq_req_rdy`=1 (the first cycle after reset deasserts), `o_shseq_run`=0, `o_shseq_ctr`=0, `o_shseq_op`=0, `o_shseq_last`=0, `o_shseq_done`=0.
- Reset mid-sequence:
  - Next cycle is IDLE with all outputs at reset values.
  - No `done` is produced.
  - Shifter state is left as is; EX discards it.
- Handshake in cycle T, amount N>0:
  - RUN occupies cycles T+1 … T+4N.
  - `done` is asserted in T+4N+1.
  - `rdy` returns in T+4N+2.
- Amount 0: `done` in T+1, `rdy` in T+2.
- Throughput: one request per 4N+2 cycles (2 for amount 0).
- `o_shseq_ctr`, `o_shseq_op`, `o_shseq_run`, `o_shseq_last` and `o_shseq_done` are registered outputs.
- `o_shseq_req_rdy` is decoded from the state register.

## Configuration
- `IDLI_SHSEQ_ROT_SHORT_EN` defined:
  - A ROR with amount > 8 is issued as ROL by 16−amount.
  - A ROL with amount > 8 is issued as ROR by 16−amount.
  - `o_shseq_op` carries the converted op. At most 8 passes are ever run.
  - SRL and other non-rotate ops are unaffected.
- Not defined: every op runs exactly amount passes in the requested direction.

## Test plan
- Reset then idle:
  - `rst`=1 for 2 cycles, then release.
  - Required: `rdy`=1, `run`=0, `done`=0, `ctr`=0.
- ROR by 3, handshake at T:
  - `run`=1 for T+1…T+12.
  - `ctr` sequence is 0,1,2,3 repeated 3 times.
  - `last`=1 in T+9…T+12.
  - `done`=1 only in T+13; `rdy`=1 in T+14.
- SRL by 0: `done` in T+1, `run` never asserted, `rdy` back in T+2.
- Kill mid-run:
  - ROL by 5 is accepted at T; kill is asserted at T+6.
  - Required: `run`=0 from T+7, no `done` pulse, `rdy`=1 at T+7.
- Kill coincident with request:
  - vld=1, rdy=1 and kill=1 in the same cycle.
  - Required: the sequencer stays IDLE and no `run` follows.
- ROR by 13:
  - With `IDLI_SHSEQ_ROT_SHORT_EN`: `o_shseq_op`=ROL, 3 passes, `done` at T+13.
  - Without it: `op`=ROR, 13 passes, `done` at T+53.

Source files
------------

// File: rtl/idli_shseq_m.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : idli_shseq_m                                                 |
// | Description : Sequencer for the single-position bit-serial shifter.        |
// |               Accepts a shift request (op, amount 0-15). It then runs      |
// |               one 4-cycle pass per position over the 16-bit operand,       |
// |               driving the shifter's slice counter and op. It pulses        |
// |               done when the result and the final carry out are valid.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Optional feature macro: IDLI_SHSEQ_ROT_SHORT_EN                            |
// |   When defined, a ROL/ROR with amount > 8 is issued as the opposite        |
// |   rotate by 16-amount, so that at most 8 passes are ever run.              |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   i_shseq_gck      in   1  clock                                           |
// |   i_shseq_rst      in   1  synchronous active-high reset                   |
// |   i_shseq_req_vld  in   1  shift request valid                             |
// |   o_shseq_req_rdy  out  1  sequencer can accept a request (IDLE)           |
// |   i_shseq_req_op   in   2  requested op (0 SRL, 1 SRA, 2 ROL, 3 ROR)       |
// |   i_shseq_req_amt  in   4  shift amount in positions                       |
// |   i_shseq_kill     in   1  flush, abandon any sequence in progress         |
// |   o_shseq_run      out  1  shifter slice active this cycle                 |
// |   o_shseq_ctr      out  2  slice counter to the shifter                    |
// |   o_shseq_op       out  2  op to the shifter (held outside RUN)            |
// |   o_shseq_last     out  1  current pass is the final pass                  |
// |   o_shseq_done     out  1  one-cycle pulse, result complete                |
// +----------------------------------------------------------------------------+
module idli_shseq_m (
  input  logic       i_shseq_gck,
  input  logic       i_shseq_rst,
  input  logic       i_shseq_req_vld,
  output logic       o_shseq_req_rdy,
  input  logic [1:0] i_shseq_req_op,
  input  logic [3:0] i_shseq_req_amt,
  input  logic       i_shseq_kill,
  output logic       o_shseq_run,
  output logic [1:0] o_shseq_ctr,
  output logic [1:0] o_shseq_op,
  output logic       o_shseq_last,
  output logic       o_shseq_done
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0] r_state;
  logic [1:0] r_ctr;
  logic [3:0] r_passes;
  logic [1:0] r_op;
  logic       r_run;
  logic       r_last;
  logic       r_done;

  logic [1:0] w_state_nxt;
  logic [1:0] w_ctr_nxt;
  logic [3:0] w_passes_nxt;
  logic [1:0] w_op_nxt;
  logic [1:0] w_req_op;
  logic [3:0] w_req_amt;

`ifdef IDLI_SHSEQ_ROT_SHORT_EN
  localparam logic [1:0] c_op_rol = 2'd2;
  localparam logic [1:0] c_op_ror = 2'd3;

  // Long rotates become the opposite rotate by 16-amount. In 4 bits,
  // 16-amount is simply the two's complement of the amount.
  always_comb begin
    w_req_op  = i_shseq_req_op;
    w_req_amt = i_shseq_req_amt;
    if (((i_shseq_req_op == c_op_rol) || (i_shseq_req_op == c_op_ror)) &&
        (i_shseq_req_amt > 4'd8)) begin
      w_req_op  = (i_shseq_req_op == c_op_rol) ? c_op_ror : c_op_rol;
      w_req_amt = 4'd0 - i_shseq_req_amt;
    end
  end
`else
  always_comb begin
    w_req_op  = i_shseq_req_op;
    w_req_amt = i_shseq_req_amt;
  end
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_ctr_nxt    = r_ctr;
    w_passes_nxt = r_passes;
    w_op_nxt     = r_op;
    case (r_state)
      c_st_idle: begin
        w_ctr_nxt = 2'd0;
        if (i_shseq_req_vld) begin
          if (w_req_amt == 4'd0) begin
            w_state_nxt = c_st_done;
          end else begin
            w_state_nxt  = c_st_run;
            w_passes_nxt = w_req_amt;
            // The op only changes on entry to RUN so the shifter's
            // stash flop always sees a stable op between passes.
            w_op_nxt     = w_req_op;
          end
        end
      end
      c_st_run: begin
        w_ctr_nxt = r_ctr + 2'd1;
        if (r_ctr == 2'd3) begin
          w_passes_nxt = r_passes - 4'd1;
          if (r_passes == 4'd1) begin
            w_state_nxt = c_st_done;
          end
        end
      end
      c_st_done: begin
        w_ctr_nxt   = 2'd0;
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_ctr_nxt   = 2'd0;
        w_state_nxt = c_st_idle;
      end
    endcase
    // Kill overrides everything, including a coincident handshake.
    if (i_shseq_kill) begin
      w_state_nxt = c_st_idle;
      w_ctr_nxt   = 2'd0;
      w_op_nxt    = r_op;
    end
  end

  always_ff @(posedge i_shseq_gck) begin
    if (i_shseq_rst) begin
      r_state  <= c_st_idle;
      r_ctr    <= 2'd0;
      r_passes <= 4'd0;
      r_op     <= 2'd0;
      r_run    <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctr    <= w_ctr_nxt;
      r_passes <= w_passes_nxt;
      r_op     <= w_op_nxt;
      r_run    <= (w_state_nxt == c_st_run);
      r_last   <= (w_state_nxt == c_st_run) && (w_passes_nxt == 4'd1);
      r_done   <= (w_state_nxt == c_st_done);
    end
  end

  assign o_shseq_req_rdy = (r_state == c_st_idle);
  assign o_shseq_run     = r_run;
  assign o_shseq_ctr     = r_ctr;
  assign o_shseq_op      = r_op;
  assign o_shseq_last    = r_last;
  assign o_shseq_done    = r_done;

endmodule
`default_nettype wire
